// File: rtl/int_vector_arbiter_if.sv
// Register bus and interrupt handshake bundle for int_vector_arbiter.
interface int_vector_arbiter_if;
  logic [2:0]  Addr;
  logic [15:0] DataRd;
  logic [15:0] DataWr;
  logic        En;
  logic        Rd;
  logic        Wr;
  logic [31:0] IntPend;
  logic [31:0] IntReset;
  logic        IntReq;
  logic        IntAck;
  logic [4:0]  IntVec;
  logic        Busy;

  modport master (
    output Addr, DataWr, En, Rd, Wr, IntPend, IntAck,
    input  DataRd, IntReset, IntReq, IntVec, Busy
  );

  modport slave (
    input  Addr, DataWr, En, Rd, Wr, IntPend, IntAck,
    output DataRd, IntReset, IntReq, IntVec, Busy
  );
endinterface

// File: rtl/int_vector_arbiter.sv
// Picks one pending interrupt source (fixed or round-robin priority), presents
// its vector to the CPU, pulses the source clear on acknowledge and waits for EOI.
module int_vector_arbiter #(
  parameter int unsigned TO_CYCLES = 1024
) (
  input logic                  Clk,
  input logic                  Reset,
  int_vector_arbiter_if.slave  bus
);

  localparam int unsigned VEC_W  = 5;
  localparam int unsigned N_SRC  = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DATA_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;
  localparam logic [1:0] ST_SERV  = 2'd3;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [VEC_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_SRC-1:0] ireset_q, ireset_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             en_q, en_d;
  logic             rr_q, rr_d;
  logic             terr_q, terr_d;

  logic             ctrl_wr;
  logic             eoi_wr;
  logic             force_idle;
  logic             timeout;
  logic [VEC_W-1:0] base;
  logic [VEC_W-1:0] cand;
  logic [VEC_W-1:0] win_idx;
  logic             win_found;
  logic [DATA_W-1:0] rd_data;

  logic unused_bits;
  assign unused_bits = ^{bus.Rd, bus.DataWr[15:3]};

  assign ctrl_wr    = bus.Wr & bus.En & (bus.Addr == 3'd0);
  assign eoi_wr     = bus.Wr & bus.En & (bus.Addr == 3'd3);
  assign force_idle = ctrl_wr & ~bus.DataWr[0];
  assign base       = rr_q ? ptr_q : '0;

  // Priority search starting at base and wrapping; fixed mode starts at 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cand = base + VEC_W'(i);
      if (!win_found && bus.IntPend[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state, vector, pointer, wait counter and clear pulse.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ireset_d = '0;
    timeout  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en_q && win_found) begin
          state_d = ST_REQ;
          vec_d   = win_idx;
          cnt_d   = '0;
        end
      end
      ST_REQ: begin
        if (bus.IntAck) begin
          state_d  = ST_CLEAR;
          ireset_d = 32'd1 << vec_q;
          cnt_d    = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_IDLE;
          timeout = 1'b1;
          ptr_d   = vec_q + 5'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_CLEAR: begin
        state_d = ST_SERV;
      end
      ST_SERV: begin
        if (eoi_wr) begin
          state_d = ST_IDLE;
          ptr_d   = vec_q + 5'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Disabling aborts whatever is in flight without clearing the source.
    if (force_idle) begin
      state_d  = ST_IDLE;
      ptr_d    = ptr_q;
      cnt_d    = '0;
      ireset_d = '0;
      timeout  = 1'b0;
    end
  end

  assign req_d  = (state_d == ST_REQ);
  assign busy_d = (state_d != ST_IDLE);

  // Control register; a timeout set beats a same-cycle write-1-to-clear.
  always_comb begin
    en_d   = en_q;
    rr_d   = rr_q;
    terr_d = terr_q;
    if (ctrl_wr) begin
      en_d = bus.DataWr[0];
      rr_d = bus.DataWr[1];
      if (bus.DataWr[2]) begin
        terr_d = 1'b0;
      end
    end
    if (timeout) begin
      terr_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      ireset_q <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      en_q     <= 1'b0;
      rr_q     <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      ireset_q <= ireset_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      en_q     <= en_d;
      rr_q     <= rr_d;
      terr_q   <= terr_d;
    end
  end

  // Register read mux.
  always_comb begin
    rd_data = '0;
    case (bus.Addr)
      3'd0:    rd_data = {13'd0, terr_q, rr_q, en_q};
      3'd1:    rd_data = {8'd0, req_q, state_q, vec_q};
      3'd2:    rd_data = {11'd0, ptr_q};
      default: rd_data = '0;
    endcase
  end

  assign bus.DataRd   = rd_data;
  assign bus.IntReset = ireset_q;
  assign bus.IntReq   = req_q;
  assign bus.IntVec   = vec_q;
  assign bus.Busy     = busy_q;

endmodule

// File: doc/int_vector_arbiter.md
INT_VECTOR_ARBITER -- requirements
Module: int_vector_arbiter

Interface
REQ-001 Parameter TO_CYCLES, default 1024: number of IntReq cycles without IntAck before the request is abandoned (range 2..65535).
REQ-002 Clk  in  1  single clock; all state changes on rising edge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 Addr  in  3  register select.
REQ-005 DataRd  out  16  register read data, combinational from Addr.
REQ-006 DataWr  in  16  register write data.
REQ-007 En  in  1  block select; a write occurs when Wr&En.
REQ-008 Rd  in  1  read strobe; informational only, reads have no side effects.
REQ-009 Wr  in  1  write strobe.
REQ-010 IntPend  in  32  masked pending sources from the interrupt controller (status AND mask).
REQ-011 IntReset  out  32  one-hot, one-cycle clear pulse to the interrupt controller.
REQ-012 IntReq  out  1  vector request to CPU.
REQ-013 IntAck  in  1  CPU acknowledge of IntVec.
REQ-014 IntVec  out  5  index of the source being requested or serviced.
REQ-015 Busy  out  1  high in any state other than IDLE.

Function
REQ-016 States: IDLE, REQ, CLEAR, SERV; encoding IDLE=0, REQ=1, CLEAR=2, SERV=3.
REQ-017 IDLE->REQ when Ctrl.Enable=1 and IntPend!=0: winner registered into IntVec on the same edge, IntReq=1 from the next cycle.
REQ-018 Fixed mode (Ctrl.RR=0): lowest-index set bit of IntPend wins.
REQ-019 Round-robin mode (Ctrl.RR=1): first set bit searching upward from Ptr wins, wrapping 31->0; the bit at Ptr itself is eligible.
REQ-020 REQ state: IntReq=1, IntVec held stable; IntVec is locked even if IntPend[IntVec] drops.
REQ-021 REQ->CLEAR on IntAck=1.
REQ-022 REQ->IDLE when a 16-bit wait counter reaches TO_CYCLES-1 without IntAck; this sets the sticky Ctrl.TimeoutErr and sets Ptr=IntVec+1 (mod 32).
REQ-023 IntAck and timeout in the same cycle: IntAck wins, no TimeoutErr.
REQ-024 CLEAR state lasts exactly one cycle: IntReset = 1<<IntVec, IntReq=0, then ->SERV; IntReset = 0 in every other cycle.
REQ-025 SERV state: waits for an EOI write (Wr&En, Addr=3, any data); on that write ->IDLE and Ptr=IntVec+1 (mod 32); EOI in any other state is ignored.
REQ-026 Writing Ctrl.Enable=0 forces IDLE on the next edge from any state: IntReq drops, no IntReset pulse, Ptr unchanged.
REQ-027 IntAck outside REQ is ignored.
REQ-028 Minimum spacing between two requests: REQ, CLEAR, SERV, IDLE, then REQ again.
REQ-029 Addr0 Ctrl, R/W: bit0 Enable, bit1 RR.
REQ-030 Addr0 Ctrl bit2 TimeoutErr is read, write-1-to-clear; a set from a timeout in the same cycle as a W1C takes priority.
REQ-031 Addr1 Status, read-only: [4:0] IntVec, [6:5] state, [7] IntReq, [15:8] 0.
REQ-032 Addr2 Ptr, read-only: [4:0] Ptr, rest 0.
REQ-033 Addr3 is a write-only EOI strobe.
REQ-034 Reads of Addr3..7 return 0; writes to Addr4..7 are ignored.

Reset
REQ-035 On Reset low, asynchronously: state=IDLE, IntReq=0, IntVec=0, IntReset=0, Busy=0, Ptr=0, Ctrl=0, wait counter=0.
REQ-036 Reset asserted mid-REQ or mid-CLEAR: IntReq and IntReset go to 0 immediately, with no partial pulse after release.
REQ-037 Block stays idle after Reset release until Enable is written to 1.

Verification
REQ-038 Fixed mode, IntPend=0x00000014: IntVec=2, IntReq=1 -> IntAck -> IntReset=0x00000004 for one cycle -> state SERV -> EOI -> IDLE, then IntVec=4.
REQ-039 RR mode, IntPend=0x80000001 held, EOI after each: grant sequence 0,31,0,31; Ptr reads 1,0,1,0.
REQ-040 TO_CYCLES=4, no IntAck: IntReq high exactly 4 cycles then IDLE, TimeoutErr=1, no IntReset pulse; W1C of bit2 -> reads 0.
REQ-041 IntAck on the final timeout cycle -> CLEAR entered, TimeoutErr stays 0.
REQ-042 Enable cleared in REQ -> IntReq=0 next cycle, IntReset stays 0; Enable cleared in SERV -> IDLE, EOI later ignored.
REQ-043 Reset low during CLEAR -> IntReset=0 and all registers at reset values in the same cycle.
